// File: rtl/avg_pool_ctrl.sv
// Average-pool sequencer: walks each channel's N x N feature map in row-major
// order, drives accumulator clear/enable and presents one average per channel.
module avg_pool_ctrl #(
  parameter int unsigned DATAWIDTH     = 32,
  parameter int unsigned MAT_DIMENSION = 13,
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned ADDR_WIDTH    = $clog2(NUM_CHANNELS*MAT_DIMENSION*MAT_DIMENSION),
  parameter int unsigned CH_WIDTH      = $clog2(NUM_CHANNELS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  acc_clr,
  output logic                  acc_en,
  input  logic [DATAWIDTH-1:0]  avg_in,
  output logic [DATAWIDTH-1:0]  out_data,
  output logic [CH_WIDTH-1:0]   out_chan,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned RC_WIDTH = $clog2(MAT_DIMENSION + 1);
  localparam int unsigned MAP_SIZE = MAT_DIMENSION * MAT_DIMENSION;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_READ, S_DRAIN, S_CAPTURE, S_RESULT, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CH_WIDTH-1:0]   ch_q, ch_d;
  logic [RC_WIDTH-1:0]   row_q, row_d;
  logic [RC_WIDTH-1:0]   col_q, col_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  busy_q, done_q, rd_en_q, acc_clr_q, acc_en_q, out_valid_q;
  logic [DATAWIDTH-1:0]  out_data_q;
  logic [CH_WIDTH-1:0]   out_chan_q;

  // Next state and counters; row/col hold the position of the read issued this cycle.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    row_d     = row_q;
    col_d     = col_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ch_d    = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        row_d   = '0;
        col_d   = '0;
        state_d = S_READ;
      end
      S_READ: begin
        if (col_q == RC_WIDTH'(MAT_DIMENSION - 1)) begin
          col_d = '0;
          if (row_q == RC_WIDTH'(MAT_DIMENSION - 1)) state_d = S_DRAIN;
          else                                       row_d   = row_q + RC_WIDTH'(1);
        end else begin
          col_d = col_q + RC_WIDTH'(1);
        end
      end
      S_DRAIN:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RESULT;
      S_RESULT: begin
        if (out_ready) begin
          if (ch_q == CH_WIDTH'(NUM_CHANNELS - 1)) begin
            state_d = S_DONE;
          end else begin
            ch_d    = ch_q + CH_WIDTH'(1);
            state_d = S_CLEAR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_READ) begin
      rd_addr_d = ADDR_WIDTH'(32'(ch_d) * MAP_SIZE + 32'(row_d) * MAT_DIMENSION + 32'(col_d));
    end
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      rd_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      acc_clr_q   <= 1'b0;
      acc_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      row_q       <= row_d;
      col_q       <= col_d;
      rd_addr_q   <= rd_addr_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      rd_en_q     <= (state_d == S_READ);
      acc_clr_q   <= (state_d == S_CLEAR);
      acc_en_q    <= rd_en_q;
      out_valid_q <= (state_d == S_RESULT);
      // The sum settled at the end of DRAIN, so avg_in is stable during CAPTURE.
      if (state_q == S_CAPTURE) begin
        out_data_q <= avg_in;
        out_chan_q <= ch_q;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign acc_clr   = acc_clr_q;
  assign acc_en    = acc_en_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_avg_pool_ctrl.sv
// Directed bench for avg_pool_ctrl: two instances (N=2,C=2 and N=1,C=3) with a
// behavioural buffer/accumulator/scaler model feeding avg_in.
module tb_avg_pool_ctrl;

  localparam int unsigned DW   = 32;
  localparam int unsigned N_A  = 2;
  localparam int unsigned C_A  = 2;
  localparam int unsigned AW_A = $clog2(C_A*N_A*N_A);
  localparam int unsigned CW_A = $clog2(C_A) + 1;
  localparam int unsigned N_B  = 1;
  localparam int unsigned C_B  = 3;
  localparam int unsigned AW_B = $clog2(C_B*N_B*N_B);
  localparam int unsigned CW_B = $clog2(C_B) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            start_a, busy_a, done_a, rd_en_a, acc_clr_a, acc_en_a, out_valid_a, ready_a;
  logic [AW_A-1:0] rd_addr_a;
  logic [DW-1:0]   avg_a, out_data_a;
  logic [CW_A-1:0] out_chan_a;

  logic            start_b, busy_b, done_b, rd_en_b, acc_clr_b, acc_en_b, out_valid_b, ready_b;
  logic [AW_B-1:0] rd_addr_b;
  logic [DW-1:0]   avg_b, out_data_b;
  logic [CW_B-1:0] out_chan_b;

  avg_pool_ctrl #(.DATAWIDTH(DW), .MAT_DIMENSION(N_A), .NUM_CHANNELS(C_A)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .acc_clr(acc_clr_a), .acc_en(acc_en_a),
    .avg_in(avg_a), .out_data(out_data_a), .out_chan(out_chan_a),
    .out_valid(out_valid_a), .out_ready(ready_a));

  avg_pool_ctrl #(.DATAWIDTH(DW), .MAT_DIMENSION(N_B), .NUM_CHANNELS(C_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .acc_clr(acc_clr_b), .acc_en(acc_en_b),
    .avg_in(avg_b), .out_data(out_data_b), .out_chan(out_chan_b),
    .out_valid(out_valid_b), .out_ready(ready_b));

  // Datapath model: 1-cycle buffer read, accumulator cleared only by acc_clr.
  real buf_a [8] = '{1.0, 2.0, 3.0, 4.0, -4.0, 0.0, 0.0, 0.0};
  real buf_b [4] = '{7.0, 8.0, 9.0, 0.0};
  real rdata_a = 0.0, sum_a = 0.0, rdata_b = 0.0, sum_b = 0.0;

  function automatic logic [31:0] to_f32(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (r == 0.0) return 32'h0;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  always @(posedge clk) begin
    if (rd_en_a) rdata_a <= buf_a[rd_addr_a];
    if (acc_clr_a) sum_a <= 0.0; else if (acc_en_a) sum_a <= sum_a + rdata_a;
    if (rd_en_b) rdata_b <= buf_b[rd_addr_b];
    if (acc_clr_b) sum_b <= 0.0; else if (acc_en_b) sum_b <= sum_b + rdata_b;
  end
  always_comb avg_a = to_f32(sum_a / real'(N_A*N_A));
  always_comb avg_b = to_f32(sum_b / real'(N_B*N_B));

  logic [31:0] exp_a [2] = '{32'h40200000, 32'hBF800000};
  logic [31:0] exp_b [3] = '{32'h40E00000, 32'h41000000, 32'h41100000};

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Cycle-by-cycle invariants on both instances.
  logic mon_en = 1'b0;
  logic rst_seen = 1'b1;
  logic rd_en_prev_a = 1'b0, rd_en_prev_b = 1'b0;
  always @(posedge clk) rst_seen <= rst;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_seen) begin
        chk("acc_en_dly_a", 32'(acc_en_a), 32'(rd_en_prev_a));
        chk("acc_en_dly_b", 32'(acc_en_b), 32'(rd_en_prev_b));
      end
      chk("clr_en_excl_a", 32'(acc_clr_a & acc_en_a), 32'd0);
      chk("clr_en_excl_b", 32'(acc_clr_b & acc_en_b), 32'd0);
      chk("done_valid_a", 32'(done_a & out_valid_a), 32'd0);
      chk("done_valid_b", 32'(done_b & out_valid_b), 32'd0);
    end
    rd_en_prev_a <= rd_en_a;
    rd_en_prev_b <= rd_en_b;
  end

  // One pass on instance A with optional RESULT stall, start pokes or mid-pass reset.
  task automatic run_a(input int stall, input bit poke, input int abort_at, input int exp_lat);
    int  scnt, ridx, eaddr, nclr;
    bit  fin, aborted;
    scnt = 0; ridx = 0; eaddr = 0; nclr = 0; fin = 0; aborted = 0;
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int n = 1; n <= 200 && !fin; n++) begin
      if (acc_clr_a) nclr++;
      if (rd_en_a) begin
        chk("rd_addr_a", 32'(rd_addr_a), 32'(eaddr));
        eaddr++;
      end
      if (out_valid_a) begin
        if (ridx < 2) begin
          chk("out_data_a", out_data_a, exp_a[ridx]);
          chk("out_chan_a", 32'(out_chan_a), 32'(ridx));
        end else begin
          chk("extra_result_a", 32'd1, 32'd0);
        end
        chk("rd_en_in_result_a", 32'(rd_en_a), 32'd0);
        if (scnt < stall) begin
          ready_a = 1'b0;
          scnt++;
        end else begin
          ready_a = 1'b1;
          ridx++;
          scnt = 0;
        end
      end
      start_a = poke && (rd_en_a || out_valid_a);
      if (done_a) begin
        chk("done_lat_a", 32'(n), 32'(exp_lat));
        fin = 1;
      end else if (abort_at >= 0 && eaddr == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ctl_a", 32'({busy_a, done_a, rd_en_a, acc_clr_a, acc_en_a, out_valid_a}), 32'd0);
        chk("abort_data_a", out_data_a, 32'd0);
        chk("abort_addr_chan_a", 32'({out_chan_a, rd_addr_a}), 32'd0);
        rst = 1'b0;
        fin = 1;
        aborted = 1;
      end
      if (!fin) @(negedge clk);
    end
    start_a = 1'b0;
    ready_a = 1'b1;
    if (!fin) chk("done_timeout_a", 32'd0, 32'd1);
    if (!aborted) begin
      chk("n_reads_a", 32'(eaddr), 32'd8);
      chk("n_clr_a", 32'(nclr), 32'd2);
      chk("n_results_a", 32'(ridx), 32'd2);
      repeat (3) begin
        @(negedge clk);
        chk("idle_after_a", 32'({busy_a, done_a}), 32'd0);
      end
    end else begin
      @(negedge clk);
    end
  endtask

  // N=1 pass on instance B.
  task automatic run_b();
    int ridx, nen;
    bit fin;
    ridx = 0; nen = 0; fin = 0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int n = 1; n <= 100 && !fin; n++) begin
      if (acc_en_b) nen++;
      if (rd_en_b) chk("rd_addr_b", 32'(rd_addr_b), 32'(n / 5));
      if (out_valid_b) begin
        if (ridx < 3) begin
          chk("out_data_b", out_data_b, exp_b[ridx]);
          chk("out_chan_b", 32'(out_chan_b), 32'(ridx));
        end else begin
          chk("extra_result_b", 32'd1, 32'd0);
        end
        ridx++;
      end
      if (done_b) begin
        chk("done_lat_b", 32'(n), 32'd16);
        fin = 1;
      end
      if (!fin) @(negedge clk);
    end
    if (!fin) chk("done_timeout_b", 32'd0, 32'd1);
    chk("n_acc_en_b", 32'(nen), 32'd3);
    chk("n_results_b", 32'(ridx), 32'd3);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ctl_a", 32'({busy_a, done_a, rd_en_a, acc_clr_a, acc_en_a, out_valid_a}), 32'd0);
    chk("rst_data_a", out_data_a, 32'd0);
    chk("rst_addr_chan_a", 32'({out_chan_a, rd_addr_a}), 32'd0);
    chk("rst_ctl_b", 32'({busy_b, done_b, rd_en_b, acc_clr_b, acc_en_b, out_valid_b}), 32'd0);
    chk("rst_addr_chan_b", 32'({out_chan_b, rd_addr_b}), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    run_a(0, 1'b0, -1, 17);
    run_a(5, 1'b0, -1, 27);
    run_a(0, 1'b1, -1, 17);
    run_a(0, 1'b0, 5, 0);
    run_a(0, 1'b0, -1, 17);
    run_b();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
